// File: rtl/keylock_pkg.sv
// Shared definitions for the keylock datapath: scanner state encoding,
// the "no key" code and the key-code mapping used by the scanner and keyList.
package keylock_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    localparam logic [7:0] KEY_NONE = 8'd0;

    // Keys are numbered row-major starting at 1 so that 0 can mean "none".
    function automatic logic [7:0] key_code(input int r, input int c, input int cols);
        return 8'(r * cols + c + 1);
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
// Flops reset to all-ones, matching the idle level of pulled-up keypad rows.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two register stages give metastability time to settle before use.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner feeding keyList.
// Drives one active-low column at a time, samples the synchronised rows at the
// end of each column's dwell, debounces a found key, and reports it as a
// latched key code plus a level button_pressed that rises once per press.
// Optional build macro KEYPAD_GHOST_REJECT_EN rejects multi-row samples in a
// column and aborts a debounce when a second row in that column goes low.
module keypad_scanner
    import keylock_pkg::*;
#(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic            hwclk,
    input  logic            reset,
    input  logic            scan_en,
    input  logic [ROWS-1:0] row_n,
    output logic [COLS-1:0] col_n,
    output logic [7:0]      key,
    output logic            button_pressed
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int CIW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RIW     = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CW-1:0]  SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  DEB_LAST  = CW'(DEBOUNCE_CNT - 1);
    localparam logic [CIW-1:0] COL_LAST  = CIW'(COLS - 1);

    scan_state_t     state, state_next;
    logic [CW-1:0]   dwell, dwell_next;
    logic [CW-1:0]   deb_cnt, deb_next;
    logic [CIW-1:0]  col_idx, col_next;
    logic [RIW-1:0]  cap_row, cap_next;
    logic [7:0]      key_next;
    logic            bp_next;

    logic [ROWS-1:0] rows_s;
    logic [ROWS-1:0] lows;
    logic            any_low;
    logic [RIW-1:0]  low_row;
    logic            cap_low;
    logic [CIW-1:0]  col_adv;
    logic            press_ok;
    logic            deb_abort;

`ifdef KEYPAD_GHOST_REJECT_EN
    logic            multi_low;
    logic            extra_low;
`endif

    sync_2ff #(
        .WIDTH(ROWS)
    ) u_row_sync (
        .clk  (hwclk),
        .reset(reset),
        .d    (row_n),
        .q    (rows_s)
    );

    // Row decode: which rows are low, the lowest-index one, and the captured row's level.
    always_comb begin
        lows    = ~rows_s;
        any_low = |lows;
        low_row = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (lows[i]) begin
                low_row = RIW'(i);
            end
        end
        cap_low = lows[cap_row];
        col_adv = (col_idx == COL_LAST) ? '0 : col_idx + CIW'(1);
    end

`ifdef KEYPAD_GHOST_REJECT_EN
    // Ghost rejection: a column sample with more than one low row is ambiguous.
    always_comb begin
        multi_low = |(lows & (lows - ROWS'(1)));
        extra_low = |(lows & ~(ROWS'(1) << cap_row));
        press_ok  = any_low && !multi_low;
        deb_abort = !cap_low || extra_low;
    end
`else
    // Without ghost rejection the lowest low row wins and other rows are ignored.
    always_comb begin
        press_ok  = any_low;
        deb_abort = !cap_low;
    end
`endif

    // Next-state logic: scan columns, debounce press, hold, debounce release.
    always_comb begin
        state_next = state;
        dwell_next = dwell;
        deb_next   = deb_cnt;
        col_next   = col_idx;
        cap_next   = cap_row;
        key_next   = key;
        bp_next    = button_pressed;

        if (!scan_en) begin
            state_next = SCAN;
            dwell_next = '0;
            deb_next   = '0;
            col_next   = '0;
            bp_next    = 1'b0;
        end else begin
            case (state)
                SCAN: begin
                    if (dwell == SCAN_LAST) begin
                        dwell_next = '0;
                        if (press_ok) begin
                            cap_next   = low_row;
                            deb_next   = '0;
                            state_next = DEBOUNCE;
                        end else begin
                            col_next = col_adv;
                        end
                    end else begin
                        dwell_next = dwell + CW'(1);
                    end
                end

                DEBOUNCE: begin
                    if (deb_abort) begin
                        state_next = SCAN;
                        dwell_next = '0;
                        deb_next   = '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        key_next   = key_code(int'(cap_row), int'(col_idx), COLS);
                        bp_next    = 1'b1;
                        deb_next   = '0;
                        state_next = HELD;
                    end else begin
                        deb_next = deb_cnt + CW'(1);
                    end
                end

                HELD: begin
                    if (!cap_low) begin
                        deb_next   = '0;
                        state_next = RELEASE;
                    end
                end

                RELEASE: begin
                    if (cap_low) begin
                        deb_next   = '0;
                        state_next = HELD;
                    end else if (deb_cnt == DEB_LAST) begin
                        bp_next    = 1'b0;
                        col_next   = col_adv;
                        dwell_next = '0;
                        deb_next   = '0;
                        state_next = SCAN;
                    end else begin
                        deb_next = deb_cnt + CW'(1);
                    end
                end

                default: begin
                    state_next = SCAN;
                    dwell_next = '0;
                    deb_next   = '0;
                end
            endcase
        end
    end

    // State, counters and outputs; col_n is registered so the column drive never glitches.
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state          <= SCAN;
            dwell          <= '0;
            deb_cnt        <= '0;
            col_idx        <= '0;
            cap_row        <= '0;
            key            <= KEY_NONE;
            button_pressed <= 1'b0;
            col_n          <= ~COLS'(1);
        end else begin
            state          <= state_next;
            dwell          <= dwell_next;
            deb_cnt        <= deb_next;
            col_idx        <= col_next;
            cap_row        <= cap_next;
            key            <= key_next;
            button_pressed <= bp_next;
            col_n          <= ~(COLS'(1) << col_next);
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=8, 4x4 keypad.
// A behavioural keypad model drives row_n from the pressed-key matrix and col_n.
// Honours KEYPAD_GHOST_REJECT_EN for the two-rows-in-one-column case.
module tb_keypad_scanner;

    logic        hwclk;
    logic        reset;
    logic        scan_en;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [7:0]  key;
    logic        button_pressed;

    logic [3:0][3:0] pressed;
    int          total;
    int          bad;
    int          rises;
    int          base_rises;
    logic        prev_bp;
    logic        seen;

    keypad_scanner #(
        .ROWS        (4),
        .COLS        (4),
        .SCAN_DIV    (4),
        .DEBOUNCE_CNT(8)
    ) dut (
        .hwclk         (hwclk),
        .reset         (reset),
        .scan_en       (scan_en),
        .row_n         (row_n),
        .col_n         (col_n),
        .key           (key),
        .button_pressed(button_pressed)
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r][c] && !col_n[c]) begin
                    row_n[r] = 1'b0;
                end
            end
        end
    end

    // Count rising edges of button_pressed to detect duplicate key events.
    always @(posedge hwclk or posedge reset) begin
        if (reset) begin
            prev_bp <= 1'b0;
        end else begin
            prev_bp <= button_pressed;
            if (button_pressed && !prev_bp) begin
                rises <= rises + 1;
            end
        end
    end

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge hwclk);
        @(negedge hwclk);
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] c, input logic v);
        pressed[r][c] = v;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitBp(input logic val, input int budget, input string tag);
        int n;
        n = 0;
        while (button_pressed !== val && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput(tag, {7'd0, button_pressed}, {7'd0, val});
    endtask

    task automatic waitCol(input logic [3:0] val, input int budget, input string tag);
        int n;
        n = 0;
        while (col_n !== val && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput(tag, {4'd0, col_n}, {4'd0, val});
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rises   = 0;
        pressed = '0;
        scan_en = 1'b1;
        reset   = 1'b1;

        // Reset state and free-running column scan.
        repeat (3) @(negedge hwclk);
        reset = 1'b0;
        checkOutput("reset_col", {4'd0, col_n}, 8'h0e);
        checkOutput("reset_key", key, 8'd0);
        checkOutput("reset_bp", {7'd0, button_pressed}, 8'd0);
        tick(3);
        checkOutput("scan_dwell_end", {4'd0, col_n}, 8'h0e);
        tick(1);
        checkOutput("scan_col1", {4'd0, col_n}, 8'h0d);
        tick(4);
        checkOutput("scan_col2", {4'd0, col_n}, 8'h0b);
        tick(4);
        checkOutput("scan_col3", {4'd0, col_n}, 8'h07);
        tick(4);
        checkOutput("scan_wrap", {4'd0, col_n}, 8'h0e);

        // Clean press of row 1 / column 2, with exact acceptance latency.
        applyStimulus(2'd1, 2'd2, 1'b1);
        waitCol(4'b1011, 20, "press_find_col2");
        tick(4);
        checkOutput("press_frozen", {4'd0, col_n}, 8'h0b);
        checkOutput("press_sample_bp", {7'd0, button_pressed}, 8'd0);
        tick(7);
        checkOutput("press_deb7_bp", {7'd0, button_pressed}, 8'd0);
        tick(1);
        checkOutput("press_accept_bp", {7'd0, button_pressed}, 8'd1);
        checkOutput("press_accept_key", key, 8'd7);
        checkOutput("press_held_col", {4'd0, col_n}, 8'h0b);

        // Clean release of the same key.
        applyStimulus(2'd1, 2'd2, 1'b0);
        tick(6);
        checkOutput("release_mid_bp", {7'd0, button_pressed}, 8'd1);
        tick(5);
        checkOutput("release_bp", {7'd0, button_pressed}, 8'd0);
        checkOutput("release_col", {4'd0, col_n}, 8'h07);
        checkOutput("release_key", key, 8'd7);

        // Bouncing contact on row 0 / column 0: never accepted.
        seen = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            applyStimulus(2'd0, 2'd0, (cyc % 5) < 3);
            tick(1);
            if (button_pressed) seen = 1'b1;
        end
        applyStimulus(2'd0, 2'd0, 1'b0);
        checkOutput("bounce_no_press", {7'd0, seen}, 8'd0);
        waitCol(4'b1110, 40, "bounce_resume_col0");
        waitCol(4'b1101, 40, "bounce_resume_col1");
        checkOutput("bounce_key", key, 8'd7);

        // Short glitch while held, then clean release and re-press of key 1.
        base_rises = rises;
        applyStimulus(2'd0, 2'd0, 1'b1);
        waitBp(1'b1, 100, "k1_press_bp");
        checkOutput("k1_press_key", key, 8'd1);
        applyStimulus(2'd0, 2'd0, 1'b0);
        tick(3);
        applyStimulus(2'd0, 2'd0, 1'b1);
        seen = 1'b0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            tick(1);
            if (!button_pressed) seen = 1'b1;
        end
        checkOutput("glitch_bp_stays", {7'd0, seen}, 8'd0);
        checkOutput("glitch_one_event", 8'(rises - base_rises), 8'd1);
        applyStimulus(2'd0, 2'd0, 1'b0);
        waitBp(1'b0, 40, "k1_release_bp");
        checkOutput("k1_release_key", key, 8'd1);
        applyStimulus(2'd0, 2'd0, 1'b1);
        waitBp(1'b1, 100, "k1_repress_bp");
        tick(1);
        checkOutput("k1_repress_key", key, 8'd1);
        checkOutput("k1_second_event", 8'(rises - base_rises), 8'd2);
        applyStimulus(2'd0, 2'd0, 1'b0);
        waitBp(1'b0, 40, "k1_final_release");

        // Rows 0 and 2 low together in column 1.
        applyStimulus(2'd0, 2'd1, 1'b1);
        applyStimulus(2'd2, 2'd1, 1'b1);
`ifdef KEYPAD_GHOST_REJECT_EN
        seen = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            tick(1);
            if (button_pressed) seen = 1'b1;
        end
        checkOutput("ghost_rejected", {7'd0, seen}, 8'd0);
        checkOutput("ghost_key_kept", key, 8'd1);
`else
        waitBp(1'b1, 100, "ghost_lowest_bp");
        checkOutput("ghost_lowest_key", key, 8'd2);
`endif
        applyStimulus(2'd0, 2'd1, 1'b0);
        applyStimulus(2'd2, 2'd1, 1'b0);
        waitBp(1'b0, 40, "ghost_release_bp");

        // Asynchronous reset in the middle of a held key.
        applyStimulus(2'd1, 2'd2, 1'b1);
        waitBp(1'b1, 100, "rst_held_bp");
        reset = 1'b1;
        #1;
        checkOutput("async_rst_bp", {7'd0, button_pressed}, 8'd0);
        checkOutput("async_rst_key", key, 8'd0);
        checkOutput("async_rst_col", {4'd0, col_n}, 8'h0e);
        applyStimulus(2'd1, 2'd2, 1'b0);
        @(negedge hwclk);
        reset = 1'b0;

        // scan_en dropped while a key is held.
        applyStimulus(2'd0, 2'd0, 1'b1);
        waitBp(1'b1, 100, "en_held_bp");
        scan_en = 1'b0;
        tick(1);
        checkOutput("en_low_bp", {7'd0, button_pressed}, 8'd0);
        checkOutput("en_low_key", key, 8'd1);
        checkOutput("en_low_col", {4'd0, col_n}, 8'h0e);
        tick(6);
        checkOutput("en_low_idle_col", {4'd0, col_n}, 8'h0e);
        applyStimulus(2'd0, 2'd0, 1'b0);
        scan_en = 1'b1;
        tick(3);
        checkOutput("en_restart_dwell", {4'd0, col_n}, 8'h0e);
        tick(1);
        checkOutput("en_restart_col1", {4'd0, col_n}, 8'h0d);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage of keyList in the FPGA keylock.
- Scans a 4x4 active-low matrix keypad, synchronises and debounces the row inputs, and produces the `key` code plus a level `button_pressed`.
- keyList consumes both signals directly.
- Exactly one key event is produced per physical press.

Parameters:
- ROWS, 4, keypad row count.
- COLS, 4, keypad column count.
- SCAN_DIV, 1000, hwclk cycles each column is driven before its rows are sampled (minimum 4).
- DEBOUNCE_CNT, 20000, consecutive stable cycles required to accept a press or a release (minimum 2).

Ports:
- hwclk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- scan_en  in  1  scanning enabled; low forces the idle scan state.
- row_n  in  ROWS  keypad rows, active-low (external pull-ups), asynchronous.
- col_n  out  COLS  column drive, one-hot active-low.
- key  out  8  latched key code: 1..ROWS*COLS, 0 = none.
- button_pressed  out  1  high while a debounced key is held.

Behaviour:
- Reset and async assert:
  - col_n = 1110 (column 0 driven), key = 0, button_pressed = 0.
  - State = SCAN; all counters 0; synchroniser flops = all-ones.
- Input synchronisation: row_n passes through a 2-flop synchroniser (rows_s). All decisions use rows_s, so there is a fixed 2-cycle input latency.
- Key code: key = r*COLS + c + 1, where r is the lowest-index low row and c is the driven column. Width is fixed at 8 bits; ROWS*COLS <= 255 is required.
- State SCAN:
  - dwell counter runs 0..SCAN_DIV-1 with the current column driven.
  - At dwell == SCAN_DIV-1, sample rows_s:
    - Any row low → capture r/c, freeze col_n, go to DEBOUNCE with deb_cnt = 0.
    - Otherwise → advance the column (COLS-1 wraps to 0) and clear dwell.
- State DEBOUNCE (col_n frozen):
  - Captured row still low and deb_cnt == DEBOUNCE_CNT-1 → key <= code, button_pressed <= 1, go to HELD. Both outputs change on the same edge.
  - Captured row goes high before that → go to SCAN, same column, dwell = 0; outputs unchanged.
- State HELD:
  - Captured row low → stay.
  - Captured row high → go to RELEASE with deb_cnt = 0.
- State RELEASE:
  - Captured row low again → return to HELD; button_pressed stays 1.
  - Captured row high for DEBOUNCE_CNT consecutive cycles → button_pressed <= 0, advance to the next column, go to SCAN.
  - key keeps its value after release until the next accepted press.
- Other keys: in DEBOUNCE/HELD/RELEASE only the captured row is examined. Other keys pressed meanwhile are ignored, with no queueing.
- scan_en:
  - scan_en low in any state → next cycle: SCAN, column 0, dwell = 0, button_pressed = 0. key is held.
  - Counters stay 0 while scan_en is low.
- Re-press of the same key: requires a full debounced release, so a new rising edge of button_pressed is guaranteed per press. keyList relies on this.
- Counter widths: $clog2 of the larger of SCAN_DIV and DEBOUNCE_CNT. Counters never wrap; they are cleared on every state change.

Optional Feature:
- Macro: KEYPAD_GHOST_REJECT_EN.
- Defined:
  - In SCAN, a sample with two or more rows low in the driven column is treated as no press; the column simply advances.
  - In DEBOUNCE, any extra row going low aborts to SCAN.
- Undefined: the lowest-index low row wins and extra rows are ignored.

Decomposition:
- Shared package keylock_pkg:
  - Scanner state encoding SCAN/DEBOUNCE/HELD/RELEASE.
  - KEY_NONE = 8'd0.
  - Key-code function (r, c, COLS) → 8-bit code, also used by keyList benches.
- One sub-module: sync_2ff (parameterised width, async reset to all-ones), instantiated on row_n.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=8, ROWS=COLS=4):
- Reset → col_n=1110, key=0, button_pressed=0. Then, with no press, col_n cycles 1110→1101→1011→0111→1110, 4 cycles each.
- Clean press, row 1 low only while col 2 is driven and held → col_n frozen at 1011; key=7 and button_pressed=1 exactly 8 cycles after the sampling edge. Release held 8 cycles → button_pressed=0, col_n=0111, key stays 7.
- Press on row 0/col 0 bouncing (low 3 cycles, high 2, repeated) → button_pressed never rises; scanning resumes.
- In HELD, 3-cycle high glitch on the captured row → button_pressed stays 1, no second event. Then a clean release/re-press of the same key → second rising edge, key=1 (row 0/col 0 key).
- Rows 0 and 2 low in column 1:
  - Macro defined → no press is accepted.
  - Macro undefined → key=2.
- Reset asserted mid-HELD (async, between edges) → outputs 0 and col_n=1110 immediately. scan_en dropped mid-HELD → button_pressed=0 next cycle, key held.
